// File: rtl/cpucr_dma_pkg.sv
// rtl/cpucr_dma_pkg.sv - shared widths and FSM state encoding for the CPUCR block-copy DMA
package cpucr_dma_pkg;

  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_LEN_W  = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_REQ     = 3'd1,
    ST_READ    = 3'd2,
    ST_WRITE   = 3'd3,
    ST_RELEASE = 3'd4
  } state_t;

endpackage

// File: rtl/cpucr_dma_if.sv
// rtl/cpucr_dma_if.sv - Direccion/Datos/LE memory bus plus SDMA/BD arbitration shared with CPUCR
interface cpucr_dma_if
  import cpucr_dma_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);

  logic              SDMA;
  logic              BD;
  logic [ADDR_W-1:0] dir_o;
  logic [DATA_W-1:0] datos_i;
  logic [DATA_W-1:0] datos_o;
  logic              LE;
  logic              bus_oe;

  modport master (
    output SDMA, dir_o, datos_o, LE, bus_oe,
    input  BD, datos_i
  );

  modport slave (
    input  SDMA, dir_o, datos_o, LE, bus_oe,
    output BD, datos_i
  );

endinterface

// File: rtl/cpucr_dma_ptr.sv
// rtl/cpucr_dma_ptr.sv - loadable address pointer; increments wrap modulo 2^ADDR_W
module cpucr_dma_ptr
  import cpucr_dma_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_val,
  input  logic              inc,
  output logic [ADDR_W-1:0] val
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      val <= '0;
    end else if (load) begin
      val <= load_val;
    end else if (inc) begin
      val <= val + ADDR_W'(1);
    end
  end

endmodule

// File: rtl/cpucr_dma.sv
// rtl/cpucr_dma.sv - memory-to-memory block copy DMA arbitrating for the CPUCR bus via SDMA/BD
// Optional completion interrupt (INT_n/INTOK) built when CPUCR_DMA_INT_EN is defined.
module cpucr_dma
  import cpucr_dma_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int LEN_W  = DEF_LEN_W
) (
  input  logic              clk,
  input  logic              RPS,
  input  logic [ADDR_W-1:0] cfg_src,
  input  logic [ADDR_W-1:0] cfg_dst,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic              cfg_start,
  cpucr_dma_if.master       bus,
  output logic              busy,
  output logic              done
`ifdef CPUCR_DMA_INT_EN
  ,
  output logic              INT_n,
  input  logic              INTOK
`endif
);

  state_t            state;
  state_t            state_nxt;
  logic [LEN_W-1:0]  cnt;
  logic [DATA_W-1:0] data_q;
  logic [ADDR_W-1:0] src;
  logic [ADDR_W-1:0] dst;
  logic              zero_done;
  logic              accept;
  logic              zero_len;
  logic              latch;
  logic              step;

  assign accept   = cfg_start && (state == ST_IDLE);
  assign zero_len = (cfg_len == '0);

  cpucr_dma_ptr #(.ADDR_W(ADDR_W)) u_src_ptr (
    .clk      (clk),
    .rst_n    (RPS),
    .load     (accept),
    .load_val (cfg_src),
    .inc      (step),
    .val      (src)
  );

  cpucr_dma_ptr #(.ADDR_W(ADDR_W)) u_dst_ptr (
    .clk      (clk),
    .rst_n    (RPS),
    .load     (accept),
    .load_val (cfg_dst),
    .inc      (step),
    .val      (dst)
  );

  // Bus outputs decode purely from state and BD, so an async reset releases the bus instantly
  // and a revoked grant drops bus_oe/LE within the same cycle.
  always_comb begin
    state_nxt   = state;
    bus.SDMA    = 1'b1;
    bus.bus_oe  = 1'b0;
    bus.LE      = 1'b0;
    bus.dir_o   = '0;
    bus.datos_o = '0;
    latch       = 1'b0;
    step        = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept && !zero_len) state_nxt = ST_REQ;
      end
      ST_REQ: begin
        bus.SDMA = 1'b0;
        if (bus.BD) state_nxt = ST_READ;
      end
      ST_READ: begin
        bus.SDMA = 1'b0;
        if (bus.BD) begin
          bus.bus_oe = 1'b1;
          bus.dir_o  = src;
          latch      = 1'b1;
          state_nxt  = ST_WRITE;
        end else begin
          state_nxt = ST_REQ;
        end
      end
      ST_WRITE: begin
        bus.SDMA = 1'b0;
        if (bus.BD) begin
          bus.bus_oe  = 1'b1;
          bus.dir_o   = dst;
          bus.datos_o = data_q;
          bus.LE      = 1'b1;
          step        = 1'b1;
          state_nxt   = (cnt == LEN_W'(1)) ? ST_RELEASE : ST_READ;
        end else begin
          state_nxt = ST_REQ;
        end
      end
      ST_RELEASE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge RPS) begin
    if (!RPS) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      data_q    <= '0;
      zero_done <= 1'b0;
    end else begin
      state     <= state_nxt;
      zero_done <= accept && zero_len;
      if (accept) begin
        cnt <= cfg_len;
      end else if (step) begin
        cnt <= cnt - LEN_W'(1);
      end
      if (latch) data_q <= bus.datos_i;
    end
  end

  assign busy = (state != ST_IDLE);
  assign done = (state == ST_RELEASE) || zero_done;

`ifdef CPUCR_DMA_INT_EN
  logic int_pend;

  always_ff @(posedge clk or negedge RPS) begin
    if (!RPS) begin
      int_pend <= 1'b0;
    end else if (state == ST_RELEASE) begin
      int_pend <= 1'b1;
    end else if (INTOK) begin
      int_pend <= 1'b0;
    end
  end

  assign INT_n = !(int_pend || (state == ST_RELEASE));
`endif

endmodule

// File: tb/tb_cpucr_dma.sv
// tb/tb_cpucr_dma.sv - scoreboard bench for cpucr_dma against a byte-array copy model
module tb_cpucr_dma;
  import cpucr_dma_pkg::*;

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  data;
  } wr_t;

  logic        clk = 1'b0;
  logic        RPS = 1'b0;
  logic [15:0] cfg_src = '0;
  logic [15:0] cfg_dst = '0;
  logic [7:0]  cfg_len = '0;
  logic        cfg_start = 1'b0;
  logic        busy;
  logic        done;
`ifdef CPUCR_DMA_INT_EN
  logic        INT_n;
  logic        INTOK = 1'b0;
`endif

  cpucr_dma_if #(.ADDR_W(16), .DATA_W(8)) bus ();

  cpucr_dma dut (
    .clk       (clk),
    .RPS       (RPS),
    .cfg_src   (cfg_src),
    .cfg_dst   (cfg_dst),
    .cfg_len   (cfg_len),
    .cfg_start (cfg_start),
    .bus       (bus),
    .busy      (busy),
    .done      (done)
`ifdef CPUCR_DMA_INT_EN
    ,
    .INT_n     (INT_n),
    .INTOK     (INTOK)
`endif
  );

  logic [7:0] mem     [0:65535];
  logic [7:0] ref_mem [0:65535];
  assign bus.datos_i = mem[bus.dir_o];

  always #5 clk = ~clk;

  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   checks = 0;
  int   failures = 0;
  wr_t  wr_q[$];
  int   rd_q[$];
  int   done_q[$];
  int   le_cnt = 0;
  int   sdma_low = 0;
  int   done_cnt = 0;
  int   oe_rise_cyc = -1;
  logic prev_oe = 1'b0;
  wr_t  e_wr;
  int   e_rd;
  int   e_done;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: memory slave writes and scoreboard pops, all sampled mid-cycle.
  always @(negedge clk) begin
    if (!RPS) begin
      prev_oe = 1'b0;
    end else begin
      chk("le_needs_oe", 32'(bus.LE & ~bus.bus_oe), 0);
      chk("oe_needs_grant", 32'(bus.bus_oe & ~(bus.BD & ~bus.SDMA)), 0);
      if (!bus.SDMA) sdma_low++;
      if (bus.bus_oe && !prev_oe) oe_rise_cyc = cyc;
      prev_oe = bus.bus_oe;
      if (bus.bus_oe && !bus.LE && rd_q.size() != 0) begin
        e_rd = rd_q.pop_front();
        chk("rd_addr", 32'(bus.dir_o), e_rd);
      end
      if (bus.LE) begin
        le_cnt++;
        mem[bus.dir_o] = bus.datos_o;
        chk("wr_expected", 32'(wr_q.size() != 0), 1);
        if (wr_q.size() != 0) begin
          e_wr = wr_q.pop_front();
          chk("wr_addr", 32'(bus.dir_o), 32'(e_wr.addr));
          chk("wr_data", 32'(bus.datos_o), 32'(e_wr.data));
        end
      end
      if (done) begin
        done_cnt++;
        chk("done_expected", 32'(done_q.size() != 0), 1);
        if (done_q.size() != 0) begin
          e_done = done_q.pop_front();
          if (e_done >= 0) chk("done_cycle", cyc, e_done);
        end
      end
    end
  end

  // dmode: 0 = exact done cycle, 1 = done cycle unknown, 2 = transfer will be aborted (no model)
  task automatic start(input logic [15:0] s, input logic [15:0] d, input logic [7:0] n,
                       input int dmode, input bit rd_chk, input int retry_idx);
    logic [15:0] a;
    logic [15:0] b;
    if (dmode != 2) begin
      for (int i = 0; i < int'(n); i++) begin
        a = s + 16'(i);
        b = d + 16'(i);
        ref_mem[b] = ref_mem[a];
        wr_q.push_back('{addr: b, data: ref_mem[b]});
        if (rd_chk) begin
          rd_q.push_back(int'(a));
          if (i == retry_idx) rd_q.push_back(int'(a));
        end
      end
    end
    @(posedge clk); #1;
    cfg_src = s; cfg_dst = d; cfg_len = n; cfg_start = 1'b1;
    if (dmode == 0) done_q.push_back(cyc + ((n == 0) ? 1 : 2 * int'(n) + 2));
    else if (dmode == 1) done_q.push_back(-1);
    @(posedge clk); #1;
    cfg_start = 1'b0;
  endtask

  task automatic wait_done(input int max, input bit rnd_bd);
    int d0 = done_cnt;
    int n = 0;
    while (done_cnt == d0 && n < max) begin
      @(posedge clk); #1;
      if (rnd_bd) bus.BD = ($urandom_range(0, 3) != 0);
      @(negedge clk); #1;
      n++;
    end
    chk("done_within_budget", 32'(done_cnt != d0), 1);
    bus.BD = 1'b1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int le0;
    int sd0;
    int r;
    logic [7:0] basic [4];
    basic[0] = 8'hA1; basic[1] = 8'hB2; basic[2] = 8'hC3; basic[3] = 8'hD4;
    for (int i = 0; i < 65536; i++) begin
      mem[i] = 8'($urandom);
      ref_mem[i] = mem[i];
    end
    for (int i = 0; i < 4; i++) begin
      mem[16'h0100 + i] = basic[i];
      ref_mem[16'h0100 + i] = basic[i];
    end
    bus.BD = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_sdma", 32'(bus.SDMA), 1);
    chk("rst_oe", 32'(bus.bus_oe), 0);
    chk("rst_le", 32'(bus.LE), 0);
    chk("rst_dir", 32'(bus.dir_o), 0);
    chk("rst_datos", 32'(bus.datos_o), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
`ifdef CPUCR_DMA_INT_EN
    chk("rst_int_n", 32'(INT_n), 1);
`endif
    RPS = 1'b1;

    // basic copy, grant already present
    le0 = le_cnt;
    start(16'h0100, 16'h0200, 8'd4, 0, 1'b1, -1);
    wait_done(40, 1'b0);
    chk("basic_le_pulses", le_cnt - le0, 4);
    chk("basic_sdma_released", 32'(bus.SDMA), 1);
    for (int i = 0; i < 4; i++) chk("basic_mem", 32'(mem[16'h0200 + i]), 32'(basic[i]));
`ifdef CPUCR_DMA_INT_EN
    chk("int_low_at_done", 32'(INT_n), 0);
    repeat (3) @(posedge clk);
    #1;
    chk("int_held", 32'(INT_n), 0);
    INTOK = 1'b1;
    @(negedge clk);
    chk("int_low_during_ok", 32'(INT_n), 0);
    @(posedge clk); #1;
    INTOK = 1'b0;
    chk("int_released", 32'(INT_n), 1);
`endif

    // zero length: no bus request at all
    le0 = le_cnt; sd0 = sdma_low;
    start(16'h0100, 16'h0300, 8'd0, 0, 1'b0, -1);
    wait_done(10, 1'b0);
    chk("zero_sdma_cycles", sdma_low - sd0, 0);
    chk("zero_le_pulses", le_cnt - le0, 0);

    // delayed grant: BD low for 5 cycles after SDMA falls
    bus.BD = 1'b0;
    start(16'h0500, 16'h0600, 8'd3, 1, 1'b1, -1);
    chk("dg_sdma_low", 32'(bus.SDMA), 0);
    repeat (5) @(posedge clk);
    #1;
    bus.BD = 1'b1;
    r = cyc;
    wait_done(40, 1'b0);
    chk("dg_first_read", oe_rise_cyc, r + 1);

    // address wrap
    start(16'hFFFE, 16'h0010, 8'd3, 0, 1'b1, -1);
    wait_done(40, 1'b0);

    // cfg_start while busy is ignored
    start(16'h0900, 16'h0A00, 8'd3, 0, 1'b0, -1);
    cfg_src = 16'h1234; cfg_dst = 16'h4321; cfg_len = 8'd9; cfg_start = 1'b1;
    @(posedge clk); #1;
    cfg_start = 1'b0;
    wait_done(40, 1'b0);

    // revoke grant during the write of byte 2 of 4
    start(16'h0700, 16'h0800, 8'd4, 1, 1'b1, 1);
    repeat (4) @(posedge clk);
    #1;
    bus.BD = 1'b0;
    @(negedge clk); #1;
    chk("rev_sdma_held", 32'(bus.SDMA), 0);
    chk("rev_oe_dropped", 32'(bus.bus_oe), 0);
    chk("rev_le_dropped", 32'(bus.LE), 0);
    @(posedge clk); #1;
    bus.BD = 1'b1;
    chk("rev_sdma_req", 32'(bus.SDMA), 0);
    wait_done(40, 1'b0);
    for (int i = 0; i < 4; i++) chk("rev_mem", 32'(mem[16'h0800 + i]), 32'(ref_mem[16'h0800 + i]));

    // randomized transfers with a wandering grant; regions may overlap
    for (int t = 0; t < 8; t++) begin
      logic [15:0] s;
      logic [15:0] d;
      logic [7:0]  n;
      s = 16'h1000 + 16'($urandom_range(0, 40));
      d = 16'h1000 + 16'($urandom_range(0, 40));
      n = 8'($urandom_range(0, 12));
      start(s, d, n, (n == 0) ? 0 : 1, 1'b0, -1);
      wait_done(400, 1'b1);
    end
    for (int i = 16'h1000; i < 16'h1040; i++) chk("rand_mem", 32'(mem[i]), 32'(ref_mem[i]));

    // asynchronous reset during the first READ
    start(16'h0300, 16'h0400, 8'd4, 2, 1'b0, -1);
    @(posedge clk); #2;
    chk("rst_pre_read_oe", 32'(bus.bus_oe), 1);
    RPS = 1'b0;
    #1;
    chk("abort_sdma", 32'(bus.SDMA), 1);
    chk("abort_oe", 32'(bus.bus_oe), 0);
    chk("abort_le", 32'(bus.LE), 0);
    chk("abort_busy", 32'(busy), 0);
    @(posedge clk); #1;
    RPS = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("abort_stays_idle", 32'(busy), 0);

    chk("wr_q_drained", wr_q.size(), 0);
    chk("rd_q_drained", rd_q.size(), 0);
    chk("done_q_drained", done_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
